// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg
// Shared definitions for the alu_issue decode/dispatch/writeback stage:
//   - RV32I opcode constants (OP, OP_IMM) and funct7 constants (BASE, EXTRA)
//   - FSM state enum
//   - instruction field positions
//   - decode(): classifies an instruction word and extracts the ALU controls
package alu_issue_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;

   localparam logic [6:0] FUNCT7_BASE  = 7'b0000000;
   localparam logic [6:0] FUNCT7_EXTRA = 7'b0100000;

   // Instruction field positions (LSB of each field).
   localparam int OPCODE_LSB = 0;
   localparam int RD_LSB     = 7;
   localparam int FUNCT3_LSB = 12;
   localparam int RS1_LSB    = 15;
   localparam int RS2_LSB    = 20;
   localparam int IMM_LSB    = 20;
   localparam int FUNCT7_LSB = 25;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DISPATCH  = 2'd1,
      WAIT      = 2'd2,
      WRITEBACK = 2'd3
   } state_t;

   typedef struct packed {
      logic            legal;
      logic [6:0]      funct7;
      logic [2:0]      funct3;
      logic            use_imm;
      logic [XLEN-1:0] imm;
   } decode_t;

   function automatic decode_t decode(input logic [31:0] instr);
      decode_t    d;
      logic [6:0] opcode;
      logic [6:0] f7;
      logic [2:0] f3;
      opcode   = instr[OPCODE_LSB +: 7];
      f7       = instr[FUNCT7_LSB +: 7];
      f3       = instr[FUNCT3_LSB +: 3];
      d        = '0;
      d.funct3 = f3;
      case (opcode)
         OP: begin
            d.funct7 = f7;
            // EXTRA only selects SUB (000) and SRA (101).
            d.legal  = (f7 == FUNCT7_BASE) ||
                       ((f7 == FUNCT7_EXTRA) && ((f3 == 3'b000) || (f3 == 3'b101)));
         end
         OP_IMM: begin
            d.use_imm = 1'b1;
            if ((f3 == 3'b001) || (f3 == 3'b101)) begin
               // Shifts: imm[11:5] doubles as funct7, shamt is imm[4:0].
               d.funct7 = f7;
               d.imm    = {27'b0, instr[IMM_LSB +: 5]};
               if (f3 == 3'b001) begin
                  d.legal = (f7 == FUNCT7_BASE);
               end else begin
                  d.legal = (f7 == FUNCT7_BASE) || (f7 == FUNCT7_EXTRA);
               end
            end else begin
               d.funct7 = FUNCT7_BASE;
               d.imm    = {{20{instr[31]}}, instr[IMM_LSB +: 12]};
               d.legal  = 1'b1;
            end
         end
         default: d.legal = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/alu_issue_register_file.sv
// register_file
// 32 x 32-bit integer register file.
//   clock, reset_n          : rising-edge clock, asynchronous active-low clear
//   rs1_addr/rs1_data       : combinational read port 1
//   rs2_addr/rs2_data       : combinational read port 2
//   write_enable/addr/data  : synchronous write port (writes to x0 are dropped)
// x0 always reads as zero.
module register_file
   import alu_issue_pkg::*;
(
   input  logic            clock,
   input  logic            reset_n,
   input  logic [4:0]      rs1_addr,
   output logic [XLEN-1:0] rs1_data,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs2_data,
   input  logic            write_enable,
   input  logic [4:0]      write_addr,
   input  logic [XLEN-1:0] write_data
);

   logic [XLEN-1:0] regs [32];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (write_enable && (write_addr != 5'd0)) begin
         regs[write_addr] <= write_data;
      end
   end

   assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
   assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/alu_issue.sv
// alu_issue
// Single-issue decode/dispatch/writeback stage in front of an external ALU.
// One instruction in flight: IDLE -> DISPATCH -> WAIT x (ALU_LATENCY-1) -> WRITEBACK.
//
// Handshake: an instruction is consumed on a rising edge where both
// instr_valid and instr_ready are high; instr_ready is high only in IDLE
// (and out of reset), so instr_valid in any other state is simply ignored.
//
// Ports:
//   clock, reset_n         : clock, asynchronous active-low reset
//   instr_valid/ready      : instruction handshake; instruction = RV32I word
//   alu_enable             : one-cycle dispatch pulse (DISPATCH state)
//   alu_funct7/funct3      : ALU operation, held until the next dispatch
//   alu_data_1/alu_data_2  : operands, held until the next dispatch
//   alu_result             : ALU output, sampled in WRITEBACK
//   retire_valid/rd/data   : one-cycle retirement report (zero otherwise)
//   illegal                : one-cycle pulse, cycle after a rejected instruction
//   retired_count          : retired-instruction counter
//   debug_state            : current FSM state
//
// Build option: define ALU_ISSUE_RETIRE_COUNT_EN to implement retired_count;
// otherwise it is tied to zero.
module alu_issue
   import alu_issue_pkg::*;
#(
   parameter int ALU_LATENCY = 1
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [31:0]     instruction,
   output logic            alu_enable,
   output logic [6:0]      alu_funct7,
   output logic [2:0]      alu_funct3,
   output logic [XLEN-1:0] alu_data_1,
   output logic [XLEN-1:0] alu_data_2,
   input  logic [XLEN-1:0] alu_result,
   output logic            retire_valid,
   output logic [4:0]      retire_rd,
   output logic [XLEN-1:0] retire_data,
   output logic            illegal,
   output logic [31:0]     retired_count,
   output logic [1:0]      debug_state
);

   // Last value of the WAIT counter before moving on (WAIT lasts ALU_LATENCY-1 cycles).
   localparam logic [1:0] WAIT_LAST = (ALU_LATENCY > 1) ? 2'(ALU_LATENCY - 2) : 2'd0;

   state_t          state, state_next;
   decode_t         dec;
   logic            accept;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic [4:0]      rd_q;
   logic [1:0]      wait_cnt;
   logic            illegal_q;

   assign dec         = decode(instruction);
   assign instr_ready = reset_n && (state == IDLE);
   assign accept      = instr_valid && instr_ready;
   assign debug_state = state;

   register_file u_register_file (
      .clock        (clock),
      .reset_n      (reset_n),
      .rs1_addr     (instruction[RS1_LSB +: 5]),
      .rs1_data     (rs1_data),
      .rs2_addr     (instruction[RS2_LSB +: 5]),
      .rs2_data     (rs2_data),
      .write_enable (retire_valid),
      .write_addr   (rd_q),
      .write_data   (alu_result)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      alu_enable   = 1'b0;
      retire_valid = 1'b0;
      case (state)
         IDLE: begin
            if (accept && dec.legal) begin
               state_next = DISPATCH;
            end
         end
         DISPATCH: begin
            alu_enable = 1'b1;
            state_next = (ALU_LATENCY > 1) ? WAIT : WRITEBACK;
         end
         WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
               state_next = WRITEBACK;
            end
         end
         WRITEBACK: begin
            retire_valid = 1'b1;
            state_next   = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand/control capture at acceptance; these stay stable through
   // DISPATCH and beyond so the ALU may sample them late.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         alu_funct7 <= '0;
         alu_funct3 <= '0;
         alu_data_1 <= '0;
         alu_data_2 <= '0;
         rd_q       <= '0;
         illegal_q  <= 1'b0;
         wait_cnt   <= '0;
      end else begin
         illegal_q <= accept && !dec.legal;
         if (accept && dec.legal) begin
            alu_funct7 <= dec.funct7;
            alu_funct3 <= dec.funct3;
            alu_data_1 <= rs1_data;
            alu_data_2 <= dec.use_imm ? dec.imm : rs2_data;
            rd_q       <= instruction[RD_LSB +: 5];
         end
         if (state == DISPATCH) begin
            wait_cnt <= '0;
         end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 2'd1;
         end
      end
   end

   assign illegal     = illegal_q;
   assign retire_rd   = retire_valid ? rd_q : '0;
   assign retire_data = retire_valid ? alu_result : '0;

`ifdef ALU_ISSUE_RETIRE_COUNT_EN
   logic [31:0] count_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (retire_valid) begin
         count_q <= count_q + 32'd1;
      end
   end

   assign retired_count = count_q;
`else
   assign retired_count = '0;
`endif

endmodule
